// File: rtl/seq_det_pkg.sv
// Shared types and default parameters for the serial pattern detector.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package seq_det_pkg;

  // FILL: history not yet deep enough to complete a pattern; ARMED: it is.
  typedef enum logic [0:0] {
    S_FILL  = 1'b0,
    S_ARMED = 1'b1
  } state_e;

  localparam int        PAT_W_DEF   = 4;
  localparam int        CNT_W_DEF   = 8;
  localparam logic [3:0] PAT_RST_DEF = 4'b1101;

endpackage

// File: rtl/seq_detect_param_if.sv
// Bundle of serial-input, control and status signals for seq_detect_param.
// Latency: n/a (wires only).
// Backpressure: none; the stream source owns in_valid, the detector never stalls it.
interface seq_detect_param_if import seq_det_pkg::*; #(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);
  logic             in_valid;
  logic             in;
  logic             overlap;
  logic             pat_load;
  logic [PAT_W-1:0] pat_in;
  logic             cnt_clr;
  logic             out;
  logic [CNT_W-1:0] match_cnt;
  logic             armed;

  // Stream/control source side.
  modport master (
    output in_valid, in, overlap, pat_load, pat_in, cnt_clr,
    input  out, match_cnt, armed
  );

  // Detector side.
  modport slave (
    input  in_valid, in, overlap, pat_load, pat_in, cnt_clr,
    output out, match_cnt, armed
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Latency: count reflects inc/clr one cycle after they are presented.
// Backpressure: none; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Reset and clear win over increment; increment stops at the maximum value.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// Serial pattern detector with loadable pattern, overlap control and match counter.
// Latency: out is Mealy (same cycle as the completing bit); match_cnt/armed one cycle later.
// Backpressure: none; a bit is consumed on every in_valid cycle, idle cycles just hold state.
module seq_detect_param import seq_det_pkg::*; #(
  parameter int               PAT_W   = PAT_W_DEF,
  // Default pattern is zero-extended when PAT_W is wider than the package default.
  parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(PAT_RST_DEF),
  parameter int               CNT_W   = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  seq_detect_param_if.slave   bus
);

  // Fill counter only needs to reach PAT_W-1.
  localparam int              FILL_W   = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

  state_e             state_q, state_d;
  logic [PAT_W-1:0]   pat_q,   pat_d;
  logic [PAT_W-2:0]   hist_q,  hist_d;
  logic [FILL_W-1:0]  fill_q,  fill_d;
  logic               armed_q;
  logic               match;
  logic               hit;
  logic [PAT_W-1:0]   window;

  // Candidate word: held history with the incoming bit as LSB (oldest bit is MSB).
  assign window = {hist_q, bus.in};

  // Next-state and Mealy match decode; pattern load beats any incoming bit.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    match   = 1'b0;

    if (bus.pat_load) begin
      pat_d   = bus.pat_in;
      hist_d  = '0;
      fill_d  = '0;
      state_d = S_FILL;
    end else if (bus.in_valid) begin
      case (state_q)
        S_FILL: begin
          hist_d = window[PAT_W-2:0];
          fill_d = fill_q + 1'b1;
          if (fill_d == FILL_MAX) begin
            state_d = S_ARMED;
          end
        end
        S_ARMED: begin
          match = (window == pat_q);
          if (match && !bus.overlap) begin
            // Non-overlapping: the matched bits cannot seed the next match.
            hist_d  = '0;
            fill_d  = '0;
            state_d = S_FILL;
          end else begin
            hist_d = window[PAT_W-2:0];
          end
        end
        default: begin
          hist_d  = '0;
          fill_d  = '0;
          state_d = S_FILL;
        end
      endcase
    end
  end

  // A reset cycle never reports a match.
  assign hit       = match & ~rst;
  assign bus.out   = hit;
  assign bus.armed = armed_q;

  // State registers; reset restores the default pattern and drops partial history.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FILL;
      pat_q   <= PAT_RST;
      hist_q  <= '0;
      fill_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      armed_q <= (state_d == S_ARMED);
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk (clk),
    .rst (rst),
    .clr (bus.cnt_clr),
    .inc (hit),
    .cnt (bus.match_cnt)
  );

endmodule

// File: tb/tb_seq_detect_param.sv
// Self-checking bench: an 8-bit-counter and a 2-bit-counter detector fed identical stimulus.
// Latency: out checked mid-cycle, registered outputs checked just after the edge.
// Backpressure: n/a.
module tb_seq_detect_param;

  logic clk;
  logic rst;

  seq_detect_param_if #(.PAT_W(4), .CNT_W(8)) bus8 ();
  seq_detect_param_if #(.PAT_W(4), .CNT_W(2)) bus2 ();

  seq_detect_param #(.PAT_W(4), .PAT_RST(4'b1101), .CNT_W(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  seq_detect_param #(.PAT_W(4), .PAT_RST(4'b1101), .CNT_W(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       r;    // rst
    logic       v;    // in_valid
    logic       d;    // in
    logic       o;    // overlap
    logic       l;    // pat_load
    logic [3:0] p;    // pat_in
    logic       c;    // cnt_clr
    logic       eo;   // expected out this cycle
    logic [7:0] ec;   // expected match_cnt after the edge (8-bit counter)
    logic       ea;   // expected armed after the edge
  } vec_t;

  typedef struct {
    logic       o;
    logic [7:0] c8;
    logic [1:0] c2;
    logic       a;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic vec_t mk(logic r, logic v, logic d, logic o, logic l, logic [3:0] p,
                              logic c, logic eo, logic [7:0] ec, logic ea);
    vec_t t;
    t.r = r; t.v = v; t.d = d; t.o = o; t.l = l; t.p = p; t.c = c;
    t.eo = eo; t.ec = ec; t.ea = ea;
    return t;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    if (act !== exp_v) begin
      n_miss++;
      $display("FAIL %s at vector %0d: got %0d, want %0d", name, n_vec, act, exp_v);
    end
  endtask

  // Drive one cycle on both detectors, queue the expectation, then compare.
  task automatic step(input vec_t t);
    exp_t e;
    logic o8, o2;
    @(negedge clk);
    rst           = t.r;
    bus8.in_valid = t.v;  bus2.in_valid = t.v;
    bus8.in       = t.d;  bus2.in       = t.d;
    bus8.overlap  = t.o;  bus2.overlap  = t.o;
    bus8.pat_load = t.l;  bus2.pat_load = t.l;
    bus8.pat_in   = t.p;  bus2.pat_in   = t.p;
    bus8.cnt_clr  = t.c;  bus2.cnt_clr  = t.c;
    e.o  = t.eo;
    e.c8 = t.ec;
    e.c2 = (t.ec > 8'd3) ? 2'd3 : t.ec[1:0];
    e.a  = t.ea;
    q.push_back(e);
    #2;
    o8 = bus8.out;
    o2 = bus2.out;
    @(posedge clk);
    #1;
    e = q.pop_front();
    n_vec++;
    chk("out8",   {7'd0, o8},             {7'd0, e.o});
    chk("out2",   {7'd0, o2},             {7'd0, e.o});
    chk("cnt8",   bus8.match_cnt,         e.c8);
    chk("cnt2",   {6'd0, bus2.match_cnt}, {6'd0, e.c2});
    chk("armed8", {7'd0, bus8.armed},     {7'd0, e.a});
    chk("armed2", {7'd0, bus2.armed},     {7'd0, e.a});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, want finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[18];
    // reset, overlapping 1101 on 1,1,0,1,1,0,1, clear, then non-overlapping run
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 8'd0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 8'd0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 8'd0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 8'd0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 8'd0, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 8'd1, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 8'd1, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 8'd1, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 8'd2, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 8'd0, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 8'd0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 8'd0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 8'd0, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 8'd0, 1'b1};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 8'd1, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 8'd1, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 8'd1, 1'b0};
    tbl[17] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 8'd1, 1'b1};

    rst = 1'b1;
    for (int i = 0; i < 18; i++) step(tbl[i]);

    // 1,1,0 with five idle cycles after each bit (in held at 1), then 1
    step(mk(1, 0, 0, 1, 0, 4'h0, 0, 0, 8'd0, 0));
    step(mk(0, 1, 1, 1, 0, 4'h0, 0, 0, 8'd0, 0));
    for (int i = 0; i < 5; i++) step(mk(0, 0, 1, 1, 0, 4'h0, 0, 0, 8'd0, 0));
    step(mk(0, 1, 1, 1, 0, 4'h0, 0, 0, 8'd0, 0));
    for (int i = 0; i < 5; i++) step(mk(0, 0, 1, 1, 0, 4'h0, 0, 0, 8'd0, 0));
    step(mk(0, 1, 0, 1, 0, 4'h0, 0, 0, 8'd0, 1));
    for (int i = 0; i < 5; i++) step(mk(0, 0, 1, 1, 0, 4'h0, 0, 0, 8'd0, 1));
    step(mk(0, 1, 1, 1, 0, 4'h0, 0, 1, 8'd1, 1));

    // pattern load on the bit that would complete 1101, then 0,1,1,0
    step(mk(1, 0, 0, 1, 0, 4'h0, 0, 0, 8'd0, 0));
    step(mk(0, 1, 1, 1, 0, 4'h0, 0, 0, 8'd0, 0));
    step(mk(0, 1, 1, 1, 0, 4'h0, 0, 0, 8'd0, 0));
    step(mk(0, 1, 0, 1, 0, 4'h0, 0, 0, 8'd0, 1));
    step(mk(0, 1, 1, 1, 1, 4'b0110, 0, 0, 8'd0, 0));
    step(mk(0, 1, 0, 1, 0, 4'h0, 0, 0, 8'd0, 0));
    step(mk(0, 1, 1, 1, 0, 4'h0, 0, 0, 8'd0, 0));
    step(mk(0, 1, 1, 1, 0, 4'h0, 0, 0, 8'd0, 1));
    step(mk(0, 1, 0, 1, 0, 4'h0, 0, 1, 8'd1, 1));

    // reset restores 1101; reset on a would-be match; no match spans reset
    step(mk(1, 0, 0, 1, 0, 4'h0, 0, 0, 8'd0, 0));
    step(mk(0, 1, 1, 1, 0, 4'h0, 0, 0, 8'd0, 0));
    step(mk(0, 1, 1, 1, 0, 4'h0, 0, 0, 8'd0, 0));
    step(mk(0, 1, 0, 1, 0, 4'h0, 0, 0, 8'd0, 1));
    step(mk(1, 1, 1, 1, 0, 4'h0, 0, 0, 8'd0, 0));
    step(mk(0, 1, 1, 1, 0, 4'h0, 0, 0, 8'd0, 0));
    step(mk(0, 1, 1, 1, 0, 4'h0, 0, 0, 8'd0, 0));
    step(mk(0, 1, 1, 1, 0, 4'h0, 0, 0, 8'd0, 1));
    step(mk(0, 1, 0, 1, 0, 4'h0, 0, 0, 8'd0, 1));
    step(mk(0, 1, 1, 1, 0, 4'h0, 0, 1, 8'd1, 1));

    // five overlapping matches saturate the 2-bit counter, then clear beats a match
    step(mk(1, 0, 0, 1, 0, 4'h0, 0, 0, 8'd0, 0));
    step(mk(0, 1, 1, 1, 0, 4'h0, 0, 0, 8'd0, 0));
    step(mk(0, 1, 1, 1, 0, 4'h0, 0, 0, 8'd0, 0));
    step(mk(0, 1, 0, 1, 0, 4'h0, 0, 0, 8'd0, 1));
    step(mk(0, 1, 1, 1, 0, 4'h0, 0, 1, 8'd1, 1));
    for (int k = 2; k <= 5; k++) begin
      step(mk(0, 1, 1, 1, 0, 4'h0, 0, 0, 8'(k - 1), 1));
      step(mk(0, 1, 0, 1, 0, 4'h0, 0, 0, 8'(k - 1), 1));
      step(mk(0, 1, 1, 1, 0, 4'h0, 0, 1, 8'(k),     1));
    end
    step(mk(0, 1, 1, 1, 0, 4'h0, 0, 0, 8'd5, 1));
    step(mk(0, 1, 0, 1, 0, 4'h0, 0, 0, 8'd5, 1));
    step(mk(0, 1, 1, 1, 0, 4'h0, 1, 1, 8'd0, 1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
